// File: rtl/digit_codes_pkg.sv
// Shared display codes and sizing helpers for the digit window scroller.
package digit_codes_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] SIGN_NEG = 4'hA;
    localparam logic [DIGIT_W-1:0] SIGN_POS = 4'hB;
    localparam logic [DIGIT_W-1:0] BLANK    = 4'hF;

    // Width of the window offset register; at least one bit even when MAX_POS is 0.
    function automatic int pos_width(input int max_pos);
        int w;
        w = $clog2(max_pos + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_step_gen.sv
// Per-button step generator: rising-edge step plus press-and-hold auto-repeat.
module btn_step_gen #(
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000
) (
    input  logic clk,
    input  logic init,
    input  logic btn,
    input  logic inhibit,
    output logic step
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;

    // A zero count means the hold was not started by an edge, so it never repeats.
    always_comb begin
        step  = 1'b0;
        cnt_d = cnt_q;
        rep_d = rep_q;
        if (!btn || inhibit) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (!prev_q) begin
            step  = 1'b1;
            cnt_d = CNT_W'(1);
            rep_d = 1'b0;
        end else if (cnt_q != '0) begin
            if (cnt_q == (rep_q ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY))) begin
                step  = 1'b1;
                cnt_d = CNT_W'(1);
                rep_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            rep_q  <= 1'b0;
        end else begin
            prev_q <= btn;
            cnt_q  <= cnt_d;
            rep_q  <= rep_d;
        end
    end

endmodule

// File: rtl/digit_window_scroller.sv
// Scrollable window over a BCD value with sign slot and leading-zero blanking.
module digit_window_scroller
    import digit_codes_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 5,
    parameter int unsigned WIN_DIGITS   = 4,
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000
) (
    input  logic                                 clk,
    input  logic                                 init,
    input  logic                                 btn_l,
    input  logic                                 btn_r,
    input  logic                                 is_neg,
    input  logic                                 blank_en,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]        digits,
    output logic [WIN_DIGITS*DIGIT_W-1:0]        digit_out,
    output logic [pos_width(int'(NUM_DIGITS) - int'(WIN_DIGITS) + 1)-1:0] pos,
    output logic                                 at_min,
    output logic                                 at_max
);

    localparam int MAX_POS = int'(NUM_DIGITS) - int'(WIN_DIGITS) + 1;
    localparam int POS_W   = pos_width(MAX_POS);
    localparam int SLOTS   = int'(WIN_DIGITS) - 1;

    logic             step_l, step_r, inhibit;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             zero_above;
    logic [DIGIT_W-1:0] disp [NUM_DIGITS];

    assign inhibit = btn_l & btn_r;

    btn_step_gen #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_step_l (
        .clk     (clk),
        .init    (init),
        .btn     (btn_l),
        .inhibit (inhibit),
        .step    (step_l)
    );

    btn_step_gen #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_step_r (
        .clk     (clk),
        .init    (init),
        .btn     (btn_r),
        .inhibit (inhibit),
        .step    (step_r)
    );

    always_comb begin
        pos_d = pos_q;
        if (step_l && pos_q != POS_W'(MAX_POS)) begin
            pos_d = pos_q + POS_W'(1);
        end else if (step_r && pos_q != '0) begin
            pos_d = pos_q - POS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    // Walk from the most significant digit down, tracking whether everything above is zero.
    always_comb begin
        zero_above = 1'b1;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            zero_above = zero_above && (digits[j*DIGIT_W +: DIGIT_W] == '0);
            disp[j] = (blank_en && j != 0 && zero_above) ? BLANK : digits[j*DIGIT_W +: DIGIT_W];
        end
    end

    always_comb begin
        digit_out = '0;
        digit_out[WIN_DIGITS*DIGIT_W-1 -: DIGIT_W] = is_neg ? SIGN_NEG : SIGN_POS;
        for (int k = 0; k < SLOTS; k++) begin
            for (int p = 0; p <= MAX_POS; p++) begin
                if (pos_q == POS_W'(p)) begin
                    digit_out[k*DIGIT_W +: DIGIT_W] = disp[p+k];
                end
            end
        end
    end

    assign pos    = pos_q;
    assign at_min = (pos_q == '0);
    assign at_max = (pos_q == POS_W'(MAX_POS));

endmodule

// File: tb/tb_digit_window_scroller.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor compares them.
module tb_digit_window_scroller;

    logic        clk = 1'b0;
    logic        init, btn_l, btn_r, is_neg, blank_en;
    logic [19:0] digits;
    logic [31:0] digits_b;
    logic [15:0] dout_a, dout_b;
    logic [1:0]  pos_a;
    logic [2:0]  pos_b;
    logic        min_a, max_a, min_b, max_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [15:0] dout;
        logic [1:0]  pos;
        logic        amin;
        logic        amax;
        bit          chk_b;
        logic [2:0]  pos_b;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] win [3];

    always #5 clk = ~clk;

    digit_window_scroller #(
        .NUM_DIGITS   (5),
        .WIN_DIGITS   (4),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4)
    ) dut_a (
        .clk       (clk),
        .init      (init),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .is_neg    (is_neg),
        .blank_en  (blank_en),
        .digits    (digits),
        .digit_out (dout_a),
        .pos       (pos_a),
        .at_min    (min_a),
        .at_max    (max_a)
    );

    digit_window_scroller #(
        .NUM_DIGITS   (8),
        .WIN_DIGITS   (4),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4)
    ) dut_b (
        .clk       (clk),
        .init      (init),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .is_neg    (is_neg),
        .blank_en  (blank_en),
        .digits    (digits_b),
        .digit_out (dout_b),
        .pos       (pos_b),
        .at_min    (min_b),
        .at_max    (max_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input string n, input logic [15:0] d, input logic [1:0] p,
                        input bit cb = 1'b0, input logic [2:0] pb = 3'd0);
        exp_t e;
        e.name  = n;
        e.dout  = d;
        e.pos   = p;
        e.amin  = (p == 2'd0);
        e.amax  = (p == 2'd2);
        e.chk_b = cb;
        e.pos_b = pb;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dout_a !== e.dout || pos_a !== e.pos || min_a !== e.amin || max_a !== e.amax ||
                (e.chk_b && pos_b !== e.pos_b)) begin
                failures++;
                $display("FAIL %s: got dout=%h pos=%0d min=%b max=%b pos_b=%0d, want dout=%h pos=%0d min=%b max=%b pos_b=%0d",
                         e.name, dout_a, pos_a, min_a, max_a, pos_b,
                         e.dout, e.pos, e.amin, e.amax, e.pos_b);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        win[0] = 16'hB345;
        win[1] = 16'hB234;
        win[2] = 16'hB123;
        init = 1'b1; btn_l = 1'b0; btn_r = 1'b0; is_neg = 1'b0; blank_en = 1'b0;
        digits = 20'h12345; digits_b = 32'h12345678;

        // Reset and mapping
        tick();
        init = 1'b0;
        push("reset", win[0], 2'd0, 1'b1, 3'd0);
        settle();
        is_neg = 1'b1;
        #1;
        push("neg_sign", 16'hA345, 2'd0);
        settle();
        is_neg = 1'b0;

        // Single steps and clamp
        btn_l = 1'b1; tick(); push("l_step1", win[1], 2'd1);
        btn_l = 1'b0; tick();
        btn_l = 1'b1; tick(); push("l_step2", win[2], 2'd2);
        btn_l = 1'b0; tick();
        btn_l = 1'b1; tick(); push("l_clamp", win[2], 2'd2);
        btn_l = 1'b0; tick();
        btn_r = 1'b1; tick(); push("r_step1", win[1], 2'd1);
        btn_r = 1'b0; tick();
        btn_r = 1'b1; tick(); push("r_step2", win[0], 2'd0);
        btn_r = 1'b0; tick();
        btn_r = 1'b1; tick(); push("r_clamp", win[0], 2'd0);
        btn_r = 1'b0; tick();

        // Auto-repeat on both widths
        init = 1'b1; tick(); init = 1'b0;
        push("rep_reset", win[0], 2'd0, 1'b1, 3'd0);
        btn_l = 1'b1; tick();
        push("rep_c0", win[1], 2'd1, 1'b1, 3'd1);
        for (int c = 1; c < 20; c++) begin
            logic [1:0] pa;
            logic [2:0] pb;
            tick();
            pa = (c >= 8) ? 2'd2 : 2'd1;
            pb = (c >= 16) ? 3'd4 : (c >= 12) ? 3'd3 : (c >= 8) ? 3'd2 : 3'd1;
            push($sformatf("rep_c%0d", c), win[pa], pa, 1'b1, pb);
        end
        btn_l = 1'b0; tick();

        // Simultaneous buttons
        init = 1'b1; tick(); init = 1'b0;
        push("sim_reset", win[0], 2'd0);
        btn_l = 1'b1; tick(); push("sim_l", win[1], 2'd1);
        btn_r = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(); push($sformatf("sim_both%0d", i), win[1], 2'd1);
        end
        btn_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); push($sformatf("sim_rrel%0d", i), win[1], 2'd1);
        end
        btn_l = 1'b0; tick(); push("sim_lrel", win[1], 2'd1);
        btn_l = 1'b1; tick(); push("sim_repress", win[2], 2'd2);
        btn_l = 1'b0; tick(); push("sim_after", win[2], 2'd2);

        // Leading-zero blanking
        init = 1'b1; tick(); init = 1'b0;
        digits = 20'h00045; blank_en = 1'b1;
        #1; push("blank_45", 16'hBF45, 2'd0);
        settle(); digits = 20'h00000;
        #1; push("blank_zero", 16'hBFF0, 2'd0);
        settle(); digits = 20'h10045;
        #1; push("blank_topnz", 16'hB045, 2'd0);
        settle(); digits = 20'h00045;
        tick();
        btn_l = 1'b1; tick(); push("blank_p1", 16'hBFF4, 2'd1);
        btn_l = 1'b0; tick();
        btn_l = 1'b1; tick(); push("blank_p2", 16'hBFFF, 2'd2);
        btn_l = 1'b0; tick();
        settle(); blank_en = 1'b0;
        #1; push("noblank_p2", 16'hB000, 2'd2);
        settle(); digits = 20'h12345;
        #1; push("digits_p2", win[2], 2'd2);

        // Reset mid-hold
        tick();
        btn_l = 1'b1; tick(); push("mh_clamp", win[2], 2'd2);
        init = 1'b1; tick(); push("mh_init", win[0], 2'd0);
        tick(); push("mh_init2", win[0], 2'd0);
        init = 1'b0; tick(); push("mh_edge", win[1], 2'd1);
        for (int c = 1; c <= 8; c++) begin
            logic [1:0] pa;
            tick();
            pa = (c >= 8) ? 2'd2 : 2'd1;
            push($sformatf("mh_c%0d", c), win[pa], pa);
        end
        btn_l = 1'b0; tick();

        settle();
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
